mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that time-shares the single memory port of the pipelined CPU between instruction fetch (IF) and the MEM-stage data access. It owns the select of the shared address/data mux2 in front of the memory, latches the winning request, runs a req/ready handshake to memory, and returns the read data plus a one-cycle ack to the requester. Data accesses have priority, and a streak counter guarantees that fetch is never starved.

## Interface
- AW, 32, address width
- DW, 32, data width
- MAX_D_BURST, 4, maximum consecutive data grants while if_req is pending (≥1)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  AW  fetch address
- if_ack  out  1  one-cycle completion pulse to fetch
- if_rdata  out  DW  fetched word, valid while if_ack=1, held afterwards
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1=write, 0=read
- d_be  in  4  byte enables
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_ack  out  1  one-cycle completion pulse to data stage
- d_rdata  out  DW  load data, valid while d_ack=1 for reads
- m_req  out  1  memory request, held until m_ready
- m_we, m_be, m_addr, m_wdata  out  1/4/AW/DW  latched request to memory
- m_ready  in  1  memory completion; m_rdata valid in the same cycle
- m_rdata  in  DW  memory read data
- sel  out  1  shared-mux select: 0=IF, 1=data; it is the owner of the current or last transaction
- busy  out  1  high in GRANT_I, GRANT_D, RESP

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D, RESP.
- IDLE: the arbiter evaluates the requests and goes to GRANT_D or GRANT_I when any request is present. It latches the address, we, be and wdata into the m_* registers and updates sel.
- The latched request fields have these sources:
  - For a fetch grant: m_we=0, m_be=4'hF, m_wdata=0.
  - For a data grant: the fields are taken from the d_* inputs.
- Priority at the IDLE decision:
  - If d_req=1 and if_req=1 and streak==MAX_D_BURST: grant IF.
  - Else if d_req=1: grant data.
  - Else if if_req=1: grant IF.
  - Else: stay in IDLE.
- Streak counter, width clog2(MAX_D_BURST+1):
  - Increments on a data grant made while if_req=1.
  - Clears on any IF grant.
  - Unchanged on a data grant made with if_req=0.
  - Saturates at MAX_D_BURST.
- GRANT_x: m_req=1 and the m_* fields are stable. When m_ready=1, the block captures m_rdata into the owner's rdata register (d_rdata only if m_we=0) and goes to RESP.
- RESP: the owner's ack=1 for exactly one cycle, m_req=0, next state IDLE. Requests are not sampled in RESP; this gives the requester one edge to advance its address or deassert.
- A requester that drops req mid-transaction is a protocol violation. The transaction still completes and the ack still pulses.
- m_ready is ignored outside GRANT_I and GRANT_D.
- Inputs other than the requests are sampled only at the IDLE grant edge. Later changes to them do not affect the m_* outputs.

## Timing
- All outputs are registered.
- Reset values: state IDLE, streak 0, and m_req, m_we, m_be, m_addr, m_wdata, if_ack, d_ack, if_rdata, d_rdata, sel and busy all 0.
- Reset asserted mid-transaction: the state returns to IDLE immediately and m_req drops asynchronously. No ack is issued for the aborted access.
- Cycle sequence, with a request seen in IDLE at cycle 0:
  - m_req rises in cycle 1.
  - If m_ready=1 in cycle k (k≥1), ack=1 in cycle k+1 (RESP) and the block is in IDLE at cycle k+2.
- Minimum cost is 3 cycles per transaction. Back-to-back throughput is one transaction per 3 cycles with zero-wait memory.
- sel changes only at the IDLE→GRANT edge. It is stable from m_req rise until the following grant.
- Simultaneous if_req and d_req are resolved only by the priority rule. Requests never queue; a loser simply keeps its req asserted.

## Test plan
- Single fetch: if_req=1, if_addr=0x0000_0100, m_ready=1 in cycle 1, m_rdata=0x2408_0005. Required: m_req=1 in cycle 1 with m_addr=0x100, m_be=F, m_we=0; if_ack=1 and if_rdata=0x2408_0005 in cycle 2; sel=0.
- Store with wait states: d_req=1, d_we=1, d_be=4'b0011, d_addr=0x40, d_wdata=0xABCD; m_ready held low for 3 cycles. Required: m_req held in cycles 1–4 with fields stable; d_ack in cycle 5; d_rdata unchanged.
- Starvation guard (MAX_D_BURST=4): if_req and d_req both held high continuously. Required grant order D,D,D,D,I,D,D,D,D,I, observed via sel and the acks.
- Simultaneous requests with streak=0: if_req=d_req=1. Required: data is granted first (sel=1); the IF grant follows in the IDLE cycle after d_ack.
- Reset mid-operation: assert rst_n=0 during GRANT_D. Required: m_req=0 and all outputs 0 immediately, no d_ack; after release, the still-pending d_req is granted again from IDLE.
- Stray m_ready: pulse m_ready in IDLE and in RESP. Required: no state change, no extra ack, rdata unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter that shares the memory port between instruction fetch and MEM-stage data access.
// Data has priority; a streak counter bounds consecutive data grants while a fetch is waiting.
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_D_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [3:0]    m_be,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ready,
  input  logic [DW-1:0] m_rdata,
  output logic          sel,
  output logic          busy
);

  localparam int SW = $clog2(MAX_D_BURST + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_BURST);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q;
  logic          grant_i, grant_d;
  logic          done_i, done_d;

  function automatic logic [SW-1:0] streak_sat_inc(input logic [SW-1:0] v);
    if (v >= STREAK_MAX) return STREAK_MAX;
    return v + 1'b1;
  endfunction

  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    done_i  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // A fetch that has waited out a full data streak wins even against a data request.
        if (d_req && if_req && (streak_q == STREAK_MAX)) begin
          grant_i = 1'b1;
          state_d = GRANT_I;
        end else if (d_req) begin
          grant_d = 1'b1;
          state_d = GRANT_D;
        end else if (if_req) begin
          grant_i = 1'b1;
          state_d = GRANT_I;
        end
      end
      GRANT_I: begin
        if (m_ready) begin
          done_i  = 1'b1;
          state_d = RESP;
        end
      end
      GRANT_D: begin
        if (m_ready) begin
          done_d  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      streak_q <= '0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_be     <= 4'h0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
      sel      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q <= state_d;
      m_req   <= (state_d == GRANT_I) || (state_d == GRANT_D);
      busy    <= (state_d != IDLE);
      if_ack  <= done_i;
      d_ack   <= done_d;

      if (grant_i) begin
        m_addr   <= if_addr;
        m_we     <= 1'b0;
        m_be     <= 4'hF;
        m_wdata  <= '0;
        sel      <= 1'b0;
        streak_q <= '0;
      end
      if (grant_d) begin
        m_addr  <= d_addr;
        m_we    <= d_we;
        m_be    <= d_be;
        m_wdata <= d_wdata;
        sel     <= 1'b1;
        if (if_req) streak_q <= streak_sat_inc(streak_q);
      end

      // Read data is captured in the completion cycle; stores leave d_rdata untouched.
      if (done_i) if_rdata <= m_rdata;
      if (done_d && !m_we) d_rdata <= m_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store with wait states, starvation guard,
// simultaneous requests, reset mid-transaction and stray m_ready.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        sel;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_D_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .sel(sel), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0;
    d_addr = 0; d_wdata = 0; m_ready = 0; m_rdata = 0;
    #1;
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL reset_m_req got=%b exp=0", m_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL reset_sel got=%b exp=0", sel); end
    checks++; if ({if_ack, d_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks got=%b exp=00", {if_ack, d_ack}); end
    checks++; if ({m_we, m_be} !== 5'h0) begin errors++; $display("FAIL reset_we_be got=%h exp=0", {m_we, m_be}); end
    checks++; if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin errors++; $display("FAIL reset_addr_wdata got=%h/%h exp=0/0", m_addr, m_wdata); end
    checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0/0", if_rdata, d_rdata); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_fetch();
    if_req = 1; if_addr = 32'h0000_0100; m_ready = 0;
    step();  // cycle 1
    checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL fetch_m_req got=%b exp=1", m_req); end
    checks++; if (m_addr !== 32'h100) begin errors++; $display("FAIL fetch_m_addr got=%h exp=00000100", m_addr); end
    checks++; if (m_be !== 4'hF || m_we !== 1'b0 || m_wdata !== 32'h0) begin errors++; $display("FAIL fetch_fields got be=%h we=%b wd=%h exp be=f we=0 wd=0", m_be, m_we, m_wdata); end
    checks++; if (sel !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL fetch_sel_busy got=%b%b exp=01", sel, busy); end
    m_ready = 1; m_rdata = 32'h2408_0005;
    step();  // cycle 2
    checks++; if (if_ack !== 1'b1 || d_ack !== 1'b0) begin errors++; $display("FAIL fetch_ack got if=%b d=%b exp if=1 d=0", if_ack, d_ack); end
    checks++; if (if_rdata !== 32'h2408_0005) begin errors++; $display("FAIL fetch_rdata got=%h exp=24080005", if_rdata); end
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL fetch_resp_m_req got=%b exp=0", m_req); end
    if_req = 0; m_ready = 0; m_rdata = 32'hFFFF_FFFF;
    step();  // cycle 3
    checks++; if (if_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fetch_idle got ack=%b busy=%b exp 0 0", if_ack, busy); end
    checks++; if (if_rdata !== 32'h2408_0005 || sel !== 1'b0) begin errors++; $display("FAIL fetch_hold got rdata=%h sel=%b exp 24080005 0", if_rdata, sel); end
  endtask

  task automatic test_store_wait();
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h40; d_wdata = 32'h0000_ABCD; m_ready = 0;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 1) begin d_wdata = 32'hDEAD_BEEF; d_addr = 32'h999; d_be = 4'hC; d_we = 0; end
      checks++;
      if (m_req !== 1'b1 || m_we !== 1'b1 || m_be !== 4'b0011 || m_addr !== 32'h40 || m_wdata !== 32'hABCD || sel !== 1'b1) begin
        errors++;
        $display("FAIL store_hold_c%0d got req=%b we=%b be=%h addr=%h wd=%h sel=%b exp 1 1 3 40 0000abcd 1",
                 c, m_req, m_we, m_be, m_addr, m_wdata, sel);
      end
      checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL store_early_ack_c%0d got=%b exp=0", c, d_ack); end
      if (c == 4) begin m_ready = 1; m_rdata = 32'h5555_5555; end
    end
    step();  // cycle 5
    checks++; if (d_ack !== 1'b1 || if_ack !== 1'b0) begin errors++; $display("FAIL store_ack got d=%b if=%b exp d=1 if=0", d_ack, if_ack); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL store_rdata got=%h exp=00000000", d_rdata); end
    d_req = 0; m_ready = 0;
    step();
    checks++; if (busy !== 1'b0 || d_ack !== 1'b0) begin errors++; $display("FAIL store_idle got busy=%b ack=%b exp 0 0", busy, d_ack); end
  endtask

  task automatic test_starvation(output logic [31:0] last_d, output logic [31:0] last_i);
    int exp_sel [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    logic [31:0] cur;
    logic got;
    cur = 32'hCAFE_0000;
    last_d = 32'h0; last_i = 32'h2408_0005;
    if_req = 1; if_addr = 32'h300; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h200;
    m_ready = 1; m_rdata = cur;
    for (int t = 0; t < 10; t++) begin
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        step();
        if (if_ack || d_ack) got = 1'b1;
      end
      checks++;
      if (!got) begin
        errors++; $display("FAIL starve_timeout_t%0d got=no_ack exp=ack", t);
      end else begin
        checks++;
        if ({d_ack, if_ack} !== ((exp_sel[t] == 1) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL starve_owner_t%0d got d/if=%b%b exp_sel=%0d", t, d_ack, if_ack, exp_sel[t]);
        end
        checks++;
        if (sel !== exp_sel[t][0]) begin errors++; $display("FAIL starve_sel_t%0d got=%b exp=%0d", t, sel, exp_sel[t]); end
        checks++;
        if (exp_sel[t] == 1) begin
          last_d = cur;
          if (d_rdata !== cur) begin errors++; $display("FAIL starve_drdata_t%0d got=%h exp=%h", t, d_rdata, cur); end
        end else begin
          last_i = cur;
          if (if_rdata !== cur) begin errors++; $display("FAIL starve_ifrdata_t%0d got=%h exp=%h", t, if_rdata, cur); end
        end
      end
      cur = cur + 1;
      m_rdata = cur;
      if (t == 9) begin if_req = 0; d_req = 0; end
    end
    m_ready = 0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL starve_end_busy got=%b exp=0", busy); end
  endtask

  task automatic test_simultaneous();
    if_req = 1; if_addr = 32'h500; d_req = 1; d_we = 0; d_addr = 32'h600; d_be = 4'hF;
    m_ready = 1; m_rdata = 32'h1111_0000;
    step();  // cycle 1
    checks++; if (sel !== 1'b1 || m_addr !== 32'h600 || m_req !== 1'b1) begin errors++; $display("FAIL simul_first got sel=%b addr=%h req=%b exp 1 600 1", sel, m_addr, m_req); end
    step();  // cycle 2
    checks++; if (d_ack !== 1'b1 || d_rdata !== 32'h1111_0000) begin errors++; $display("FAIL simul_dack got ack=%b rdata=%h exp 1 11110000", d_ack, d_rdata); end
    d_req = 0; m_rdata = 32'h2222_0000;
    step();  // cycle 3: IDLE
    checks++; if (busy !== 1'b0 || sel !== 1'b1) begin errors++; $display("FAIL simul_idle got busy=%b sel=%b exp 0 1", busy, sel); end
    step();  // cycle 4
    checks++; if (sel !== 1'b0 || m_req !== 1'b1 || m_addr !== 32'h500) begin errors++; $display("FAIL simul_fetch got sel=%b req=%b addr=%h exp 0 1 500", sel, m_req, m_addr); end
    step();  // cycle 5
    checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h2222_0000) begin errors++; $display("FAIL simul_iack got ack=%b rdata=%h exp 1 22220000", if_ack, if_rdata); end
    if_req = 0; m_ready = 0;
    step();
  endtask

  task automatic test_reset_mid();
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h700; m_ready = 0;
    step();  // GRANT_D
    checks++; if (m_req !== 1'b1 || sel !== 1'b1) begin errors++; $display("FAIL rstmid_grant got req=%b sel=%b exp 1 1", m_req, sel); end
    #2 rst_n = 0;
    #1;
    checks++; if (m_req !== 1'b0 || busy !== 1'b0 || sel !== 1'b0) begin errors++; $display("FAIL rstmid_async got req=%b busy=%b sel=%b exp 0 0 0", m_req, busy, sel); end
    checks++; if (m_addr !== 32'h0 || m_be !== 4'h0 || d_rdata !== 32'h0 || if_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_clear got addr=%h be=%h drd=%h ird=%h exp 0", m_addr, m_be, d_rdata, if_rdata); end
    m_ready = 1; m_rdata = 32'h3333_3333;
    step();
    checks++; if (d_ack !== 1'b0 || m_req !== 1'b0) begin errors++; $display("FAIL rstmid_noack got ack=%b req=%b exp 0 0", d_ack, m_req); end
    m_ready = 0;
    rst_n = 1;
    step();  // regranted from IDLE
    checks++; if (m_req !== 1'b1 || sel !== 1'b1 || m_addr !== 32'h700) begin errors++; $display("FAIL rstmid_regrant got req=%b sel=%b addr=%h exp 1 1 700", m_req, sel, m_addr); end
    m_ready = 1; m_rdata = 32'h4444_0001;
    step();
    checks++; if (d_ack !== 1'b1 || d_rdata !== 32'h4444_0001) begin errors++; $display("FAIL rstmid_ack got ack=%b rdata=%h exp 1 44440001", d_ack, d_rdata); end
    d_req = 0; m_ready = 0;
    step();
  endtask

  task automatic test_stray_ready();
    m_ready = 1; m_rdata = 32'hBAD0_0001;
    step();
    step();
    checks++; if (busy !== 1'b0 || m_req !== 1'b0 || if_ack !== 1'b0 || d_ack !== 1'b0) begin errors++; $display("FAIL stray_idle got busy=%b req=%b acks=%b%b exp 0 0 00", busy, m_req, if_ack, d_ack); end
    checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h4444_0001) begin errors++; $display("FAIL stray_idle_rdata got=%h/%h exp 0/44440001", if_rdata, d_rdata); end
    m_ready = 0; if_req = 1; if_addr = 32'h800;
    step();  // GRANT_I
    m_ready = 1; m_rdata = 32'h7777_0008;
    step();  // RESP
    checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h7777_0008) begin errors++; $display("FAIL stray_fetch got ack=%b rdata=%h exp 1 77770008", if_ack, if_rdata); end
    if_req = 0; m_rdata = 32'hBAD0_0002;
    step();  // IDLE, m_ready still high
    checks++; if (if_ack !== 1'b0 || busy !== 1'b0 || if_rdata !== 32'h7777_0008) begin errors++; $display("FAIL stray_resp got ack=%b busy=%b rdata=%h exp 0 0 77770008", if_ack, busy, if_rdata); end
    step();
    checks++; if (if_ack !== 1'b0 || d_ack !== 1'b0 || m_req !== 1'b0) begin errors++; $display("FAIL stray_after got acks=%b%b req=%b exp 00 0", if_ack, d_ack, m_req); end
    m_ready = 0;
  endtask

  initial begin
    logic [31:0] last_d, last_i;
    test_reset();
    test_single_fetch();
    test_store_wait();
    test_starvation(last_d, last_i);
    checks++; if (d_rdata !== last_d || if_rdata !== last_i) begin errors++; $display("FAIL starve_hold got=%h/%h exp=%h/%h", d_rdata, if_rdata, last_d, last_i); end
    test_simultaneous();
    test_reset_mid();
    test_stray_ready();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
